redun_from_conv: RTL and testbench

- Sequential converter from the 17-bit-per-word redundant form (65 words × (WRD_BITS+1) bits) back to the plain 1040-bit field element.
- It is the hardware counterpart of the software from_redun / check_overflow helpers.
- It sits at the output of the redundant Montgomery squaring datapath and resolves carries a few words per cycle, instead of using one 1040-bit adder chain.
- It also flags the case where the value does not fit in DAT_BITS.

---
 rtl/redun_from_conv.sv | 112 +++++++++++
 tb/tb_redun_from_conv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/redun_from_conv.sv
// rtl/redun_from_conv.sv - redundant (17-bit word) to plain 1040-bit converter
// Resolves carries WRDS_PER_CYC words per cycle and flags results that overflow DAT_BITS.
module redun_from_conv #(
  parameter int WRD_BITS     = 16,
  parameter int NUM_WRDS     = 65,
  parameter int WRDS_PER_CYC = 5
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
  input  logic                             i_val,
  output logic                             o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]     o_dat,
  output logic                             o_ovf,
  output logic                             o_val,
  input  logic                             i_rdy
);

  localparam int W1       = WRD_BITS + 1;
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int IN_BITS  = NUM_WRDS * W1;
  localparam int NCHUNK   = NUM_WRDS / WRDS_PER_CYC;
  localparam int CHK_IN   = WRDS_PER_CYC * W1;
  localparam int CHK_OUT  = WRDS_PER_CYC * WRD_BITS;
  localparam int CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (NUM_WRDS % WRDS_PER_CYC != 0) begin : g_bad_chunking
    $error("redun_from_conv: WRDS_PER_CYC must divide NUM_WRDS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         carry;
  logic [IN_BITS-1:0] in_reg;

  logic [CHK_IN-1:0]   chunk_in;
  logic [CHK_OUT-1:0]  chunk_out;
  logic [1:0]          carry_out;
  logic [WRD_BITS+1:0] t;

  // Ripple through the current chunk; the carry never exceeds 2, so 2 bits suffice.
  always_comb begin
    chunk_in  = in_reg[cnt*CHK_IN +: CHK_IN];
    chunk_out = '0;
    carry_out = carry;
    t         = '0;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      t = {1'b0, chunk_in[j*W1 +: W1]} + {{WRD_BITS{1'b0}}, carry_out};
      chunk_out[j*WRD_BITS +: WRD_BITS] = t[WRD_BITS-1:0];
      carry_out = t[WRD_BITS+1:WRD_BITS];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= '0;
      in_reg <= '0;
      o_rdy  <= 1'b1;
      o_val  <= 1'b0;
      o_dat  <= '0;
      o_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_val) begin
            in_reg <= i_dat;
            carry  <= '0;
            cnt    <= '0;
            o_rdy  <= 1'b0;
            state  <= CONV;
          end
        end
        CONV: begin
          o_dat[cnt*CHK_OUT +: CHK_OUT] <= chunk_out;
          carry <= carry_out;
          if (cnt == CNT_W'(NCHUNK - 1)) begin
            o_ovf <= |carry_out;
            o_val <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // No skid path: the next operand is only taken once back in IDLE.
          if (i_rdy) begin
            o_val <= 1'b0;
            o_rdy <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          o_rdy <= 1'b1;
          o_val <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic unused_width_ok;
  assign unused_width_ok = (DAT_BITS == NCHUNK * CHK_OUT);

endmodule

// File: tb/tb_redun_from_conv.sv
// tb/tb_redun_from_conv.sv - randomized self-checking bench for redun_from_conv
module tb_redun_from_conv;
  localparam int WB = 16;
  localparam int NW = 65;
  localparam int W1 = WB + 1;
  localparam int DB = NW * WB;
  localparam int IW = NW * W1;
  localparam int LAT = 14;
  localparam int NRAND = 1000;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [IW-1:0] i_dat = '0;
  logic          i_val = 1'b0;
  logic          o_rdy;
  logic [DB-1:0] o_dat;
  logic          o_ovf;
  logic          o_val;
  logic          i_rdy = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  redun_from_conv #(.WRD_BITS(WB), .NUM_WRDS(NW), .WRDS_PER_CYC(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dat(i_dat), .i_val(i_val), .o_rdy(o_rdy),
    .o_dat(o_dat), .o_ovf(o_ovf), .o_val(o_val), .i_rdy(i_rdy)
  );

  task automatic check(input string tag, input logic [DB+15:0] got, input logic [DB+15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      for (int k = 0; k < (DB + 16) / 16; k++) begin
        if (got[k*16 +: 16] !== exp[k*16 +: 16]) begin
          $display("FAIL %s: word %0d got %h expected %h", tag, k, got[k*16 +: 16], exp[k*16 +: 16]);
          break;
        end
      end
    end
  endtask

  // Big-integer sum of word_k * 2^(16k); bits above DB are the overflow.
  function automatic logic [DB+15:0] model(input logic [IW-1:0] d);
    logic [DB+15:0] acc;
    logic [DB+15:0] w;
    acc = '0;
    for (int k = 0; k < NW; k++) begin
      w = '0;
      w[W1-1:0] = d[k*W1 +: W1];
      acc = acc + (w << (k * WB));
    end
    return acc;
  endfunction

  function automatic logic [IW-1:0] rand_op();
    logic [IW-1:0] d;
    for (int k = 0; k < NW; k++) d[k*W1 +: W1] = W1'($urandom_range(32'h1FFFF));
    return d;
  endfunction

  task automatic run_one(input string tag, input logic [IW-1:0] d, input logic [DB-1:0] exp_dat,
                         input logic exp_ovf, input int hold);
    int lat;
    logic seen;
    check({tag, "_rdy_before"}, o_rdy, 1);
    i_dat = d;
    i_val = 1'b1;
    i_rdy = (hold == 0);
    @(negedge i_clk);
    i_val = 1'b0;
    i_dat = ~d;
    lat = 1;
    check({tag, "_rdy_busy"}, o_rdy, 0);
    while (!o_val && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_dat"}, o_dat, exp_dat);
    check({tag, "_ovf"}, o_ovf, exp_ovf);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        if (h == 5) begin i_val = 1'b1; i_dat = rand_op(); end
        if (h == 6) i_val = 1'b0;
        @(negedge i_clk);
        check({tag, "_hold_val"}, o_val, 1);
        check({tag, "_hold_rdy"}, o_rdy, 0);
        check({tag, "_hold_dat"}, o_dat, exp_dat);
        check({tag, "_hold_ovf"}, o_ovf, exp_ovf);
      end
      i_rdy = 1'b1;
    end
    @(negedge i_clk);
    i_rdy = 1'b0;
    check({tag, "_val_drop"}, o_val, 0);
    check({tag, "_rdy_back"}, o_rdy, 1);
    if (hold > 0) begin
      seen = 1'b0;
      for (int h = 0; h < 18; h++) begin
        @(negedge i_clk);
        if (o_val || !o_rdy) seen = 1'b1;
      end
      check({tag, "_no_accept"}, seen, 0);
    end
  endtask

  logic [IW-1:0] d;
  logic [DB-1:0] e;
  logic [DB+15:0] m;
  logic [WB-1:0] p [NW];
  logic seen;

  logic [DB-1:0] qd [$];
  logic          qo [$];
  int            qt [$];
  logic [IW-1:0] cur;
  logic          pend;
  logic          prev_val;
  int sent, got, cyc;

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_rdy", o_rdy, 1);
    check("rst_val", o_val, 0);
    check("rst_dat", o_dat, 0);
    check("rst_ovf", o_ovf, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // canonical words pass through untouched
    for (int k = 0; k < NW; k++) begin
      d[k*W1 +: W1] = W1'(k + 1);
      e[k*WB +: WB] = WB'(k + 1);
    end
    run_one("canon", d, e, 1'b0, 0);

    // a single carry ripples across every chunk boundary
    d = '0; e = '0;
    d[0 +: W1] = 17'h1FFFF;
    for (int k = 1; k < 64; k++) d[k*W1 +: W1] = 17'h0FFFF;
    e[0 +: WB] = 16'hFFFF;
    e[64*WB +: WB] = 16'h0001;
    run_one("ripple", d, e, 1'b0, 0);

    // all-ones redundant words overflow; held under backpressure
    for (int k = 0; k < NW; k++) d[k*W1 +: W1] = 17'h1FFFF;
    m = model(d);
    run_one("ovf", d, m[DB-1:0], |m[DB+15:DB], 20);

    // async reset in the middle of a conversion
    i_dat = rand_op();
    i_val = 1'b1;
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    repeat (5) @(negedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_rdy", o_rdy, 1);
    check("arst_val", o_val, 0);
    check("arst_dat", o_dat, 0);
    check("arst_ovf", o_ovf, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int h = 0; h < 16; h++) begin
      @(negedge i_clk);
      if (o_val) seen = 1'b1;
    end
    check("arst_no_val", seen, 0);

    // P rewritten in redundant form by borrowing from odd words into even ones
    for (int k = 0; k < NW; k++) begin
      p[k] = WB'($urandom);
      if (k % 2 == 1) p[k] = p[k] | 16'h0001;
      e[k*WB +: WB] = p[k];
      d[k*W1 +: W1] = {1'b0, p[k]};
    end
    for (int k = 0; k < 64; k += 2) begin
      d[k*W1 +: W1] = {1'b1, p[k]};
      d[(k+1)*W1 +: W1] = {1'b0, p[k+1] - 16'd1};
    end
    run_one("post_rst", d, e, 1'b0, 0);

    // random regression with random valid/ready gaps
    sent = 0; got = 0; cyc = 0; pend = 1'b0; prev_val = 1'b0; cur = '0;
    while ((sent < NRAND || got < sent) && cyc < 60000) begin
      @(negedge i_clk);
      cyc++;
      if (!pend && sent < NRAND && $urandom_range(3) != 0) begin
        cur = rand_op();
        pend = 1'b1;
      end
      i_val = pend;
      i_dat = pend ? cur : rand_op();
      i_rdy = ($urandom_range(3) != 0);
      if (o_val && !prev_val && qt.size() > 0) check("rnd_lat", cyc - qt[0], LAT);
      prev_val = o_val;
      if (o_val && i_rdy) begin
        if (qd.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          check("rnd_dat", o_dat, qd[0]);
          check("rnd_ovf", o_ovf, qo[0]);
          void'(qd.pop_front());
          void'(qo.pop_front());
          void'(qt.pop_front());
          got++;
        end
        prev_val = 1'b0;
      end
      if (i_val && o_rdy) begin
        m = model(cur);
        qd.push_back(m[DB-1:0]);
        qo.push_back(|m[DB+15:DB]);
        qt.push_back(cyc);
        sent++;
        pend = 1'b0;
      end
    end
    i_val = 1'b0;
    i_rdy = 1'b0;
    check("rnd_count", got, NRAND);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
